// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with 2-entry output queue
//
// Purpose: keeps the fetch PC, issues one outstanding instruction-memory
// request at a time, buffers returned words with their PCs for decode and
// handles redirects, dropping any fetch already in flight.
//
// Build option: FETCH_MISALIGN_FAULT_EN - when defined, a redirect to a
// non word-aligned target halts fetch and raises the sticky fault output.
// When undefined the low target bits are cleared and fault stays 0.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   imem_req/addr       fetch request and address (from registered state only)
//   imem_ack/rdata      request completion and instruction word
//   redirect/_pc        one-cycle redirect pulse and target
//   inst/inst_pc        queue head word and its PC
//   inst_valid/ready    queue head handshake towards decode
//   fault               sticky misaligned-redirect fault
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        fault
);

  typedef enum logic [1:0] {RUN, DROP, HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] fpc_next_q, fpc_next_d;
  logic        halt_pend_q, halt_pend_d;
  logic        active_q;
  logic [1:0]  count_q, count_d;
  logic [31:0] word_q [2];
  logic [31:0] word_d [2];
  logic [31:0] pc_q [2];
  logic [31:0] pc_d [2];

  logic [31:0] tgt;
  logic        misalign;
  logic        pop;
  logic        push;
  logic        wr_idx;

`ifdef FETCH_MISALIGN_FAULT_EN
  assign tgt      = redirect_pc;
  assign misalign = |redirect_pc[1:0];
`else
  assign tgt      = redirect_pc & 32'hFFFF_FFFC;
  assign misalign = 1'b0;
`endif

  // active_q keeps the request low in the first cycle after reset release.
  assign imem_req   = active_q && ((state_q == RUN && count_q != 2'd2) || state_q == DROP);
  assign imem_addr  = fpc_q;
  assign inst       = word_q[0];
  assign inst_pc    = pc_q[0];
  assign inst_valid = (count_q != 2'd0);
  assign fault      = (state_q == HALT);

  assign pop    = inst_valid && inst_ready;
  assign push   = imem_req && imem_ack;
  // Slot written by a push once this cycle's pop has shifted the queue.
  assign wr_idx = (count_q == 2'd1) && !pop;

  always_comb begin
    state_d     = state_q;
    fpc_d       = fpc_q;
    fpc_next_d  = fpc_next_q;
    halt_pend_d = halt_pend_q;
    count_d     = count_q;
    word_d      = word_q;
    pc_d        = pc_q;
    unique case (state_q)
      RUN: begin
        if (redirect) begin
          count_d = 2'd0;
          if (imem_req && !imem_ack) begin
            // Request cannot be withdrawn: wait for it in DROP.
            state_d     = DROP;
            fpc_next_d  = tgt;
            halt_pend_d = misalign;
          end else if (misalign) begin
            state_d = HALT;
          end else begin
            fpc_d = tgt;
          end
        end else begin
          if (pop) begin
            word_d[0] = word_q[1];
            pc_d[0]   = pc_q[1];
          end
          if (push) begin
            word_d[wr_idx] = imem_rdata;
            pc_d[wr_idx]   = fpc_q;
            fpc_d          = fpc_q + 32'd4;
          end
          count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
      end
      DROP: begin
        count_d = 2'd0;
        if (redirect && imem_ack) begin
          // Old request finishes now, so the new target needs no drain.
          if (misalign) state_d = HALT;
          else begin
            fpc_d   = tgt;
            state_d = RUN;
          end
        end else if (redirect) begin
          fpc_next_d  = tgt;
          halt_pend_d = misalign;
        end else if (imem_ack) begin
          if (halt_pend_q) state_d = HALT;
          else begin
            fpc_d   = fpc_next_q;
            state_d = RUN;
          end
        end
      end
      HALT: begin
        count_d = 2'd0;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      fpc_q       <= RESET_PC;
      fpc_next_q  <= RESET_PC;
      halt_pend_q <= 1'b0;
      active_q    <= 1'b0;
      count_q     <= 2'd0;
      word_q[0]   <= 32'd0;
      word_q[1]   <= 32'd0;
      pc_q[0]     <= 32'd0;
      pc_q[1]     <= 32'd0;
    end else begin
      state_q     <= state_d;
      fpc_q       <= fpc_d;
      fpc_next_q  <= fpc_next_d;
      halt_pend_q <= halt_pend_d;
      active_q    <= 1'b1;
      count_q     <= count_d;
      word_q      <= word_d;
      pc_q        <= pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic        fault;

  int          n_tests = 0;
  int          n_fail = 0;
  int          lat = 0;
  int          mem_wc = 0;
  bit          mon_en = 1'b0;
  logic [31:0] sb [$];
  logic [31:0] mon_exp;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .fault      (fault)
  );

  function automatic logic [31:0] mkword(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3C3_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Instruction memory: acks after 'lat' wait cycles of a held request.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (imem_req) begin
        if (mem_wc >= lat) begin
          imem_ack   = 1'b1;
          imem_rdata = mkword(imem_addr);
          mem_wc     = 0;
        end else begin
          imem_ack = 1'b0;
          mem_wc++;
        end
      end else begin
        imem_ack = 1'b0;
        mem_wc   = 0;
      end
    end
  end

  // Decode side: every consumed instruction must match the scoreboard head.
  always @(negedge clk) begin
    if (mon_en && inst_valid && inst_ready) begin
      if (sb.size() == 0) begin
        check("sb_extra_inst", 32'(sb.size()), 32'd1);
      end else begin
        mon_exp = sb.pop_front();
        check("inst_pc", inst_pc, mon_exp);
        check("inst", inst, mkword(mon_exp));
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = 32'd0;
    mon_en = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'h0000_0100);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_pc", inst_pc, 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    do begin
      @(posedge clk);
      k++;
    end while (sb.size() != 0 && k < 60);
    check({tag, "_drained"}, 32'(sb.size()), 32'd0);
    #1;
    mon_en = 1'b0;
    inst_ready = 1'b0;
  endtask

  task automatic wait_head(input logic [31:0] pc, input string tag);
    int k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!(inst_valid && inst_pc == pc) && k < 40);
    check(tag, inst_pc, pc);
  endtask

  initial begin
    int k;
    // Streaming at one instruction per cycle from RESET_PC.
    lat = 0;
    inst_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) sb.push_back(32'h100 + 32'(4 * i));
    mon_en = 1'b1;
    @(negedge clk);
    check("t1_req_rel0", 32'(imem_req), 32'd0);
    check("t1_valid_rel0", 32'(inst_valid), 32'd0);
    @(negedge clk);
    check("t1_req_rel1", 32'(imem_req), 32'd1);
    check("t1_addr_rel1", imem_addr, 32'h100);
    check("t1_valid_rel1", 32'(inst_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t1_stream_valid", 32'(inst_valid), 32'd1);
    end
    drain("t1");

    // Stalled decode: queue fills to two and requests stop.
    lat = 0;
    inst_ready = 1'b0;
    do_reset();
    repeat (10) @(negedge clk);
    check("t2_req_full", 32'(imem_req), 32'd0);
    check("t2_valid_full", 32'(inst_valid), 32'd1);
    check("t2_head_pc", inst_pc, 32'h100);
    for (int i = 0; i < 4; i++) sb.push_back(32'h100 + 32'(4 * i));
    @(posedge clk);
    #1;
    inst_ready = 1'b1;
    mon_en = 1'b1;
    drain("t2");

    // Redirect while a slow request is pending.
    lat = 3;
    inst_ready = 1'b1;
    do_reset();
    sb.push_back(32'h100);
    sb.push_back(32'h104);
    sb.push_back(32'h200);
    sb.push_back(32'h204);
    mon_en = 1'b1;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!(imem_req && imem_addr == 32'h108) && k < 80);
    check("t3_reach_108", imem_addr, 32'h108);
    @(posedge clk);
    #1;
    redirect = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    check("t3_addr_w1", imem_addr, 32'h108);
    @(posedge clk);
    #1 redirect = 1'b0;
    @(negedge clk);
    check("t3_addr_w2", imem_addr, 32'h108);
    check("t3_req_w2", 32'(imem_req), 32'd1);
    check("t3_valid_flushed", 32'(inst_valid), 32'd0);
    @(negedge clk);
    check("t3_addr_ack", imem_addr, 32'h108);
    @(negedge clk);
    check("t3_addr_target", imem_addr, 32'h200);
    check("t3_req_target", 32'(imem_req), 32'd1);
    drain("t3");

    // Redirect coincident with an ack and a pop.
    lat = 0;
    inst_ready = 1'b1;
    do_reset();
    sb.push_back(32'h100);
    sb.push_back(32'h104);
    sb.push_back(32'h300);
    sb.push_back(32'h304);
    mon_en = 1'b1;
    wait_head(32'h104, "t4_reach_104");
    redirect = 1'b1;
    redirect_pc = 32'h300;
    @(posedge clk);
    #1 redirect = 1'b0;
    @(negedge clk);
    check("t4_valid_flushed", 32'(inst_valid), 32'd0);
    check("t4_addr_target", imem_addr, 32'h300);
    check("t4_req_target", 32'(imem_req), 32'd1);
    drain("t4");

    // Misaligned redirect target.
    lat = 0;
    inst_ready = 1'b1;
    do_reset();
    sb.push_back(32'h100);
    sb.push_back(32'h104);
`ifndef FETCH_MISALIGN_FAULT_EN
    sb.push_back(32'h200);
    sb.push_back(32'h204);
`endif
    mon_en = 1'b1;
    wait_head(32'h104, "t5_reach_104");
    redirect = 1'b1;
    redirect_pc = 32'h202;
    @(posedge clk);
    #1 redirect = 1'b0;
    @(negedge clk);
`ifdef FETCH_MISALIGN_FAULT_EN
    check("t5_fault", 32'(fault), 32'd1);
    check("t5_req_halt", 32'(imem_req), 32'd0);
    check("t5_valid_halt", 32'(inst_valid), 32'd0);
    redirect = 1'b1;
    redirect_pc = 32'h400;
    @(posedge clk);
    #1 redirect = 1'b0;
    repeat (5) @(negedge clk);
    check("t5_fault_sticky", 32'(fault), 32'd1);
    check("t5_req_sticky", 32'(imem_req), 32'd0);
`else
    check("t5_fault_off", 32'(fault), 32'd0);
    check("t5_addr_aligned", imem_addr, 32'h200);
    check("t5_req_aligned", 32'(imem_req), 32'd1);
`endif
    drain("t5");

    // Redirect with a full queue, then fetch wraps past the top of memory.
    lat = 0;
    inst_ready = 1'b0;
    do_reset();
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!(inst_valid && !imem_req) && k < 20);
    check("t6_full_req", 32'(imem_req), 32'd0);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(posedge clk);
    #1 redirect = 1'b0;
    @(negedge clk);
    check("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
    check("t6_req_top", 32'(imem_req), 32'd1);
    check("t6_valid_flushed", 32'(inst_valid), 32'd0);
    @(negedge clk);
    check("t6_addr_wrap", imem_addr, 32'h0000_0000);
    check("t6_head_top", inst_pc, 32'hFFFF_FFFC);
    sb.push_back(32'hFFFF_FFFC);
    sb.push_back(32'h0000_0000);
    @(posedge clk);
    #1;
    inst_ready = 1'b1;
    mon_en = 1'b1;
    drain("t6");

    do_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
